// File: rtl/cnn_pkg.sv
// Shared CNN pipeline types and defaults, common to convolution and max_pool_2x2.
package cnn_pkg;

    localparam int unsigned DEFAULT_WORD_SIZE    = 8;
    localparam int unsigned DEFAULT_ROW_SIZE     = 540;
    localparam int unsigned DEFAULT_IMAGE_HEIGHT = 360;

    typedef logic [DEFAULT_WORD_SIZE-1:0] pixel_t;

    function automatic pixel_t pixel_max(input pixel_t a, input pixel_t b);
        return (a > b) ? a : b;
    endfunction

    // Counter width that never collapses to zero bits for tiny test geometries.
    function automatic int unsigned clog2_min(input int unsigned n, input int unsigned floor_w);
        int unsigned w;
        w = $clog2(n);
        return (w < floor_w) ? floor_w : w;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Half-row line buffer for max_pool_2x2: simple dual-port RAM with one write port and one
// synchronous read port whose output register holds until the next read.
module pool_line_buffer #(
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned DEPTH     = 270,
    parameter int unsigned ADDR_W    = 9
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_W-1:0]    waddr_i,
    input  logic [WORD_SIZE-1:0] wdata_i,
    input  logic                 re_i,
    input  logic [ADDR_W-1:0]    raddr_i,
    output logic [WORD_SIZE-1:0] rdata_o
);

    logic [WORD_SIZE-1:0] mem_q [DEPTH];
    logic [WORD_SIZE-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 max-pooling stage. Define MAX_POOL_FRAME_DONE_EN to add the frameDone
// end-of-frame strobe. WORD_SIZE must match cnn_pkg::DEFAULT_WORD_SIZE (pixel_t).
module max_pool_2x2
    import cnn_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = DEFAULT_WORD_SIZE,
    parameter int unsigned ROW_SIZE     = DEFAULT_ROW_SIZE,
    parameter int unsigned IMAGE_HEIGHT = DEFAULT_IMAGE_HEIGHT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] inputPixel,
    input  logic                 inValid,
    output logic [WORD_SIZE-1:0] outputPixel,
`ifdef MAX_POOL_FRAME_DONE_EN
    output logic                 frameDone,
`endif
    output logic                 outValid
);

    localparam int unsigned COL_W  = clog2_min(ROW_SIZE, 2);
    localparam int unsigned ROW_W  = clog2_min(IMAGE_HEIGHT, 1);
    localparam int unsigned ADDR_W = COL_W - 1;

    logic [COL_W-1:0]     col_q, col_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [WORD_SIZE-1:0] hold_q, hold_d;
    logic [WORD_SIZE-1:0] out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 frame_done_q, frame_done_d;

    logic                 accept;
    logic                 last_col, last_row;
    logic                 lb_we, lb_re;
    logic [ADDR_W-1:0]    lb_addr;
    logic [WORD_SIZE-1:0] lb_wdata, lb_rdata;

    // Reset wins over a simultaneous accept, so the pixel is dropped.
    assign accept   = inValid && !rst;
    assign last_col = (col_q == COL_W'(ROW_SIZE - 1));
    assign last_row = (row_q == ROW_W'(IMAGE_HEIGHT - 1));
    assign lb_addr  = col_q[COL_W-1:1];
    assign lb_wdata = pixel_max(hold_q, inputPixel);
    assign lb_we    = accept && !row_q[0] && col_q[0];
    assign lb_re    = accept && row_q[0] && !col_q[0];

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        out_d        = out_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        if (accept) begin
            if (!col_q[0]) begin
                hold_d = inputPixel;
            end else if (row_q[0]) begin
                out_d        = pixel_max(lb_rdata, pixel_max(hold_q, inputPixel));
                out_valid_d  = 1'b1;
                frame_done_d = last_row && last_col;
            end
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    pool_line_buffer #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (ROW_SIZE / 2),
        .ADDR_W    (ADDR_W)
    ) u_line_buffer (
        .clk_i   (clk),
        .we_i    (lb_we),
        .waddr_i (lb_addr),
        .wdata_i (lb_wdata),
        .re_i    (lb_re),
        .raddr_i (lb_addr),
        .rdata_o (lb_rdata)
    );

    assign outputPixel = out_q;
    assign outValid    = out_valid_q;

`ifdef MAX_POOL_FRAME_DONE_EN
    assign frameDone = frame_done_q;
`else
    logic unused_frame_done;
    assign unused_frame_done = frame_done_q;
`endif

endmodule

// File: doc/max_pool_2x2.md
# max_pool_2x2

Streaming 2×2 max-pooling stage placed directly downstream of `convolution`. It consumes convolved pixels in raster order, one per valid cycle. It emits one pooled pixel per non-overlapping 2×2 window, producing an output image of (ROW_SIZE/2)×(IMAGE_HEIGHT/2) in raster order. A half-row line buffer holds the horizontal maxima of each even row until the matching odd row arrives.

## Interface
- `WORD_SIZE`, 8: pixel width, unsigned.
- `ROW_SIZE`, 540: input pixels per row; must be even.
- `IMAGE_HEIGHT`, 360: input rows per frame; must be even.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `inputPixel`  in  WORD_SIZE  pixel from `convolution`.
- `inValid`  in  1  `inputPixel` is accepted this cycle.
- `outputPixel`  out  WORD_SIZE  pooled pixel, registered.
- `outValid`  out  1  one-cycle strobe marking `outputPixel` valid.
- `frameDone`  out  1  present only with `MAX_POOL_FRAME_DONE_EN`; see Configuration.

## Operation
- Counters `col` (0..ROW_SIZE-1) and `row` (0..IMAGE_HEIGHT-1).
  - Both advance only on `inValid`.
  - `col` wraps to 0 and increments `row`.
  - `row` wraps to 0 after the last pixel of a frame. The next frame starts immediately with no idle cycles.
- `hold` register: on an even-column accept, `hold <= inputPixel`.
- Even row, odd column: write `max(hold, inputPixel)` to line buffer address `col>>1`.
- Odd row, even column: issue a line buffer read at address `col>>1`.
- Odd row, odd column: `outputPixel <= max(lbData, hold, inputPixel)` and `outValid <= 1`.
- No output on any other cycle.
- Comparisons are unsigned and WORD_SIZE wide. No widening and no saturation.
- There is no backpressure; the downstream consumer must accept every strobe.
- `inValid` low: counters, `hold` and buffer all hold their values; `outValid` is 0 that cycle.

## Timing
- Reset values: `outputPixel`=0, `outValid`=0, `frameDone`=0, `col`=0, `row`=0, `hold`=0. Line buffer contents are don't-care.
- Latency: `outValid` rises the cycle after the accept of the bottom-right pixel of a window.
- Throughput: at most one output per 4 accepted pixels. Outputs occur only during odd rows, at most every 2nd cycle.
- Line buffer read is synchronous (1 cycle). The read issued at the even-column accept is consumed at the odd-column accept, even if `inValid` gaps occur between them. `lbData` must therefore be held until consumed.
- Write and read never target the same address in the same cycle, because writes happen only in even rows and reads only in odd rows.
- `rst` mid-frame:
  - Counters return to (0,0) the next cycle.
  - Partial window state is discarded and no stale output is emitted.
  - Stale buffer data is always overwritten before it is read.
- `rst` and `inValid` asserted together: reset wins and the pixel is dropped.

## Configuration
- `MAX_POOL_FRAME_DONE_EN` defined:
  - Adds the `frameDone` port.
  - `frameDone` pulses high for one cycle, coincident with the `outValid` of the last pooled pixel of a frame (row IMAGE_HEIGHT-1, col ROW_SIZE-1).
  - Reset value 0.
- Undefined: the port and its logic are absent. Pooling behaviour is identical in both cases.

## Structure
- Shared package `cnn_pkg`:
  - `pixel_t` (logic [WORD_SIZE-1:0]).
  - `function pixel_max(a, b)`.
  - Default `WORD_SIZE`, `ROW_SIZE` and `IMAGE_HEIGHT` constants, shared with `convolution`.
- Sub-module `pool_line_buffer`:
  - Simple dual-port RAM, ROW_SIZE/2 × WORD_SIZE.
  - One write port, one synchronous read port, no reset on storage.
- The top level holds the counters, `hold`, the compare logic and the output registers.

## Test plan
- ROW_SIZE=4, IMAGE_HEIGHT=4, frame 1..16 raster, `inValid` continuously high -> outputs 6, 8, 14, 16 in that order. Each `outValid` comes one cycle after the accepts of pixels 6, 8, 14, 16. With the macro defined, `frameDone` is high together with 16.
- Same frame with `inValid` toggling 1,0 -> same four values. `outValid` never asserts on a cycle following an `inValid`=0 cycle without a new accept.
- Window {FF,00;00,01} -> FF. Window {00,00;00,00} -> 00. Window {7F,80;80,7F} -> 80, confirming the compare is unsigned.
- Two back-to-back frames, the second with values 100..115 -> 105, 107, 113, 115. No gap cycles are required between frames.
- Assert `rst` after 7 pixels, then send a fresh 16-pixel frame -> no output before the fresh frame's pixel 6. Outputs exactly match the first scenario.
- Default parameters, 540×360 frame of constant 0x5A -> 48600 strobes, all 0x5A. Exactly one `frameDone` when the macro is defined.
